ring_monitor: RTL and testbench

- Consumer stage placed directly downstream of ring_counter.
- Samples the one-hot ring vector every clock and decodes it to a binary index.
- Checks every cycle-to-cycle transition for a legal single-bit rotation, locks onto a healthy ring and counts full revolutions.
- Raises a sticky fault on corruption: zero-hot, multi-hot or a skipped position.

---
 rtl/ring_monitor.sv | 146 ++++++++++++++
 tb/tb_ring_monitor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_monitor.sv
// Ring-counter consumer: decodes the one-hot ring to an index, locks onto legal rotation,
// counts revolutions and flags corruption. Optional macro RING_MONITOR_REV_SAT_EN saturates out_rev_cnt.
module ring_monitor #(
   parameter int WIDTH_REG   = 32,
   parameter int LOCK_CYCLES = 4,
   parameter int REV_WIDTH   = 16
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic [WIDTH_REG-1:0]          in_ring,
   input  logic                          clr_err,
   output logic [$clog2(WIDTH_REG)-1:0]  out_index,
   output logic                          out_valid,
   output logic                          out_wrap,
   output logic [REV_WIDTH-1:0]          out_rev_cnt,
   output logic                          out_err
);

   localparam int IDX_W  = $clog2(WIDTH_REG);
   localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   localparam logic [1:0] ST_SEARCH = 2'd0;
   localparam logic [1:0] ST_LOCKED = 2'd1;
   localparam logic [1:0] ST_FAULT  = 2'd2;

   localparam logic [LOCK_W-1:0]    LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
   localparam logic [LOCK_W-1:0]    LOCK_ONE  = LOCK_W'(1);
   localparam logic [REV_WIDTH-1:0] REV_ONE   = REV_WIDTH'(1);
   localparam logic [WIDTH_REG-1:0] RING_ONE  = WIDTH_REG'(1);

   function automatic logic is_onehot(input logic [WIDTH_REG-1:0] v);
      return (v != '0) && ((v & (v - RING_ONE)) == '0);
   endfunction

   function automatic logic [IDX_W-1:0] encode(input logic [WIDTH_REG-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < WIDTH_REG; i++) begin
         if (v[i]) begin
            idx = IDX_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   function automatic logic [REV_WIDTH-1:0] rev_next(input logic [REV_WIDTH-1:0] r);
`ifdef RING_MONITOR_REV_SAT_EN
      return (r == '1) ? r : r + REV_ONE;
`else
      return r + REV_ONE;
`endif
   endfunction

   logic [WIDTH_REG-1:0] cur_r, prev_r;
   logic                 loaded_r, prev_vld_r;
   logic [LOCK_W-1:0]    lock_cnt_r, lock_s;
   logic [1:0]           state_r, state_s;
   logic [REV_WIDTH-1:0] rev_s;
   logic                 wrap_s, onehot_s, legal_s;

   assign onehot_s = is_onehot(cur_r);
   // A step is legal only when the current sample is the previous one rotated left by exactly one.
   assign legal_s  = prev_vld_r & onehot_s &
                     (cur_r == {prev_r[WIDTH_REG-2:0], prev_r[WIDTH_REG-1]});

   // Lock / fault state machine and revolution bookkeeping.
   always_comb begin
      state_s = state_r;
      lock_s  = lock_cnt_r;
      rev_s   = out_rev_cnt;
      wrap_s  = 1'b0;
      case (state_r)
         ST_SEARCH: begin
            if (legal_s) begin
               if (lock_cnt_r == LOCK_LAST) begin
                  state_s = ST_LOCKED;
                  lock_s  = '0;
               end else begin
                  lock_s  = lock_cnt_r + LOCK_ONE;
               end
            end else if (prev_vld_r) begin
               lock_s = '0;
            end else begin
               lock_s = lock_cnt_r;
            end
         end
         ST_LOCKED: begin
            if (!legal_s) begin
               state_s = ST_FAULT;
            end else if (prev_r[WIDTH_REG-1]) begin
               wrap_s = 1'b1;
               rev_s  = rev_next(out_rev_cnt);
            end else begin
               wrap_s = 1'b0;
            end
         end
         ST_FAULT: begin
            if (clr_err) begin
               state_s = ST_SEARCH;
               rev_s   = '0;
               lock_s  = '0;
            end else begin
               state_s = ST_FAULT;
            end
         end
         default: begin
            state_s = ST_SEARCH;
            lock_s  = '0;
            rev_s   = '0;
         end
      endcase
   end

   // Sampling pipeline, FSM state and registered outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cur_r       <= '0;
         prev_r      <= '0;
         loaded_r    <= 1'b0;
         prev_vld_r  <= 1'b0;
         lock_cnt_r  <= '0;
         state_r     <= ST_SEARCH;
         out_index   <= '0;
         out_valid   <= 1'b0;
         out_wrap    <= 1'b0;
         out_rev_cnt <= '0;
         out_err     <= 1'b0;
      end else begin
         prev_r      <= cur_r;
         cur_r       <= in_ring;
         loaded_r    <= 1'b1;
         prev_vld_r  <= loaded_r;
         lock_cnt_r  <= lock_s;
         state_r     <= state_s;
         // A corrupted sample leaves the last good position visible.
         out_index   <= onehot_s ? encode(cur_r) : out_index;
         out_valid   <= (state_s == ST_LOCKED);
         out_wrap    <= wrap_s;
         out_rev_cnt <= rev_s;
         out_err     <= (state_s == ST_FAULT);
      end
   end

endmodule

// File: tb/tb_ring_monitor.sv
// Self-checking bench for ring_monitor: directed scenarios plus randomized ring traffic
// compared every cycle against a position-arithmetic reference model.
module tb_ring_monitor;

   localparam int W  = 32;
   localparam int LC = 4;
   localparam int RW = 2;
   localparam int REV_MAX = (1 << RW) - 1;

   logic          clk = 1'b0;
   logic          n_rst;
   logic [W-1:0]  in_ring;
   logic          clr_err;
   logic [4:0]    out_index;
   logic          out_valid;
   logic          out_wrap;
   logic [RW-1:0] out_rev_cnt;
   logic          out_err;

   int checks   = 0;
   int failures = 0;

   // model: positions as integers (-1 = corrupt sample), state 0 search / 1 locked / 2 fault
   logic [W-1:0] m_cur, m_prev;
   bit           m_loaded, m_pvld, m_wrap;
   int           m_state, m_lock, m_index, m_rev;

   ring_monitor #(.WIDTH_REG(W), .LOCK_CYCLES(LC), .REV_WIDTH(RW)) dut (
      .clk(clk), .n_rst(n_rst), .in_ring(in_ring), .clr_err(clr_err),
      .out_index(out_index), .out_valid(out_valid), .out_wrap(out_wrap),
      .out_rev_cnt(out_rev_cnt), .out_err(out_err)
   );

   always #5 clk = ~clk;

   function automatic int pos_of(input logic [W-1:0] v);
      int n = 0;
      int p = -1;
      for (int i = 0; i < W; i++) begin
         if (v[i]) begin
            n++;
            p = i;
         end
      end
      return (n == 1) ? p : -1;
   endfunction

   function automatic logic [W-1:0] hot(input int p);
      logic [W-1:0] one = 1;
      return one << (p % W);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cur = '0; m_prev = '0; m_loaded = 0; m_pvld = 0; m_wrap = 0;
      m_state = 0; m_lock = 0; m_index = 0; m_rev = 0;
   endtask

   task automatic model_edge();
      int  pc, pp;
      bit  legal;
      pc = pos_of(m_cur);
      pp = pos_of(m_prev);
      legal = m_pvld && pc >= 0 && pp >= 0 && pc == (pp + 1) % W;
      if (pc >= 0) m_index = pc;
      m_wrap = 0;
      if (m_state == 0) begin
         if (legal) begin
            if (m_lock == LC - 1) begin
               m_state = 1;
               m_lock  = 0;
            end else begin
               m_lock++;
            end
         end else if (m_pvld) begin
            m_lock = 0;
         end
      end else if (m_state == 1) begin
         if (!legal) begin
            m_state = 2;
         end else if (pp == W - 1) begin
            m_wrap = 1;
`ifdef RING_MONITOR_REV_SAT_EN
            m_rev = (m_rev == REV_MAX) ? REV_MAX : m_rev + 1;
`else
            m_rev = (m_rev + 1) % (REV_MAX + 1);
`endif
         end
      end else begin
         if (clr_err) begin
            m_state = 0;
            m_rev   = 0;
            m_lock  = 0;
         end
      end
      m_pvld   = m_loaded;
      m_loaded = 1;
      m_prev   = m_cur;
      m_cur    = in_ring;
   endtask

   task automatic check_all();
      chk("index", out_index, m_index);
      chk("valid", out_valid, (m_state == 1));
      chk("wrap", out_wrap, m_wrap);
      chk("rev_cnt", out_rev_cnt, m_rev);
      chk("err", out_err, (m_state == 2));
   endtask

   task automatic drive(input logic [W-1:0] v, input logic c);
      in_ring = v;
      clr_err = c;
      @(posedge clk);
      if (n_rst) model_edge();
      #1;
      check_all();
   endtask

   initial begin
      int p;
      int r;
      logic [W-1:0] v;
      n_rst = 1'b0; in_ring = '0; clr_err = 1'b0;
      model_reset();
      #3;
      check_all();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;

      // lock from k = 0: out_valid rises on edge 6, index lags by two edges
      for (int j = 0; j < 8; j++) begin
         drive(hot(j), 1'b0);
         if (j + 1 == 5) chk("lock_e5_valid", out_valid, 1'b0);
         if (j + 1 == 6) chk("lock_e6_valid", out_valid, 1'b1);
         if (j + 1 >= 2) chk("lag_index", out_index, j - 1);
      end

      // two full wraps
      for (int j = 8; j < 66; j++) begin
         drive(hot(j), 1'b0);
         if (j == 33) chk("rev_first", out_rev_cnt, 1);
      end
      chk("rev_second", out_rev_cnt, 2);

      // skipped position while locked, then resume legal rotation
      drive(32'h0000_0004, 1'b0);
      drive(32'h0000_0010, 1'b0);
      for (int j = 5; j < 9; j++) drive(hot(j), 1'b0);
      chk("skip_err", out_err, 1'b1);
      chk("skip_valid", out_valid, 1'b0);

      // clear and re-lock after four legal steps
      drive(hot(9), 1'b1);
      chk("clr_err", out_err, 1'b0);
      chk("clr_rev", out_rev_cnt, 0);
      for (int j = 10; j < 14; j++) drive(hot(j), 1'b0);
      chk("relock_valid", out_valid, 1'b1);

      // clr_err while locked has no effect
      drive(hot(14), 1'b1);
      chk("clr_locked_valid", out_valid, 1'b1);

      // multi-hot
      drive(32'h0000_0003, 1'b0);
      drive(hot(16), 1'b0);
      chk("multi_err", out_err, 1'b1);
      chk("multi_index_hold", out_index, 14);
      drive(hot(17), 1'b1);
      for (int j = 18; j < 22; j++) drive(hot(j), 1'b0);
      chk("relock2_valid", out_valid, 1'b1);

      // zero-hot
      drive(32'h0000_0000, 1'b0);
      drive(hot(23), 1'b0);
      chk("zero_err", out_err, 1'b1);
      chk("zero_index_hold", out_index, 21);
      drive(hot(24), 1'b1);
      for (int j = 25; j < 29; j++) drive(hot(j), 1'b0);

      // randomized traffic: mostly legal steps with repeats, skips, garbage and stray clears
      p = 28;
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         if (r < 85) begin
            p++;
            v = hot(p);
         end else if (r < 90) begin
            v = hot(p);
         end else if (r < 95) begin
            v = $urandom;
         end else begin
            p += 2;
            v = hot(p);
         end
         drive(v, ($urandom_range(0, 19) == 0));
      end

      // get locked, then async reset mid-cycle
      p++;
      drive(hot(p), (m_state == 2));
      for (int j = 0; j < 6; j++) begin
         p++;
         drive(hot(p), 1'b0);
      end
      chk("pre_reset_valid", out_valid, 1'b1);
      p++;
      drive(hot(p), 1'b0);
      #2;
      n_rst = 1'b0;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      n_rst = 1'b1;

      // fresh lock, then five revolutions
      p = $urandom_range(0, W - 1);
      for (int j = 0; j < 6; j++) drive(hot(p + j), 1'b0);
      chk("post_reset_lock", out_valid, 1'b1);
      chk("post_reset_rev", out_rev_cnt, 0);
      for (int j = 6; j < 166; j++) drive(hot(p + j), 1'b0);
`ifdef RING_MONITOR_REV_SAT_EN
      chk("rev_five", out_rev_cnt, 3);
`else
      chk("rev_five", out_rev_cnt, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
